// File: rtl/mc_sequencer_if.sv
// Control/strobe bundle between the multicycle sequencer and the core around it.
// Counter signals exist only when MC_PERF_CNT_EN is defined.
interface mc_sequencer_if
`ifdef MC_PERF_CNT_EN
   #(parameter int CNT_W = 32)
`endif
   ;
   logic       RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite;
   logic       Branch, Jump, RegDst_ra, JumptoReg;
   logic [3:0] ALUctrl;
   logic       imem_ready, dmem_ready;
   logic       imem_req, ir_we, pc_we, pc_we_cond;
   logic [1:0] pc_src;
   logic       dmem_req, dmem_we, mdr_we, rf_we;
   logic [3:0] alu_ctrl_q, ctrl_q;
   logic [2:0] state;
   logic       instr_done;
`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt, instr_cnt, stall_cnt;
`endif

   modport master (
      input  RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
             Branch, Jump, RegDst_ra, JumptoReg, ALUctrl, imem_ready, dmem_ready,
      output imem_req, ir_we, pc_we, pc_we_cond, pc_src, dmem_req, dmem_we,
             mdr_we, rf_we, alu_ctrl_q, ctrl_q, state, instr_done
`ifdef MC_PERF_CNT_EN
      , output cycle_cnt, instr_cnt, stall_cnt
`endif
   );

   modport slave (
      output RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
             Branch, Jump, RegDst_ra, JumptoReg, ALUctrl, imem_ready, dmem_ready,
      input  imem_req, ir_we, pc_we, pc_we_cond, pc_src, dmem_req, dmem_we,
             mdr_we, rf_we, alu_ctrl_q, ctrl_q, state, instr_done
`ifdef MC_PERF_CNT_EN
      , input cycle_cnt, instr_cnt, stall_cnt
`endif
   );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle MIPS step sequencer: IF/ID/EX/MEM/WB strobes with req/ready memory handshakes.
// Optional performance counters under MC_PERF_CNT_EN.
module mc_sequencer
`ifdef MC_PERF_CNT_EN
   #(parameter int CNT_W = 32)
`endif
   (
   input logic           clk,
   input logic           rst,
   mc_sequencer_if.master bus
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_IF   = 3'd1;
   localparam logic [2:0] S_ID   = 3'd2;
   localparam logic [2:0] S_EX   = 3'd3;
   localparam logic [2:0] S_MEM  = 3'd4;
   localparam logic [2:0] S_WB   = 3'd5;

   logic [2:0] r_state, w_next;
   logic       r_regdst, r_alusrc, r_memtoreg, r_regwrite, r_memread, r_memwrite;
   logic       r_branch, r_jump, r_regdst_ra, r_jumptoreg;
   logic [3:0] r_aluctrl;

   logic       w_imem_req, w_ir_we, w_pc_we, w_pc_we_cond;
   logic [1:0] w_pc_src;
   logic       w_dmem_req, w_dmem_we, w_mdr_we, w_rf_we, w_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_regdst    <= 1'b0;
         r_alusrc    <= 1'b0;
         r_memtoreg  <= 1'b0;
         r_regwrite  <= 1'b0;
         r_memread   <= 1'b0;
         r_memwrite  <= 1'b0;
         r_branch    <= 1'b0;
         r_jump      <= 1'b0;
         r_regdst_ra <= 1'b0;
         r_jumptoreg <= 1'b0;
         r_aluctrl   <= 4'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_ID) begin
            r_regdst    <= bus.RegDst;
            r_alusrc    <= bus.ALUSrc;
            r_memtoreg  <= bus.MemToReg;
            r_regwrite  <= bus.RegWrite;
            r_memread   <= bus.MemRead;
            r_memwrite  <= bus.MemWrite;
            r_branch    <= bus.Branch;
            r_jump      <= bus.Jump;
            r_regdst_ra <= bus.RegDst_ra;
            r_jumptoreg <= bus.JumptoReg;
            r_aluctrl   <= bus.ALUctrl;
         end
      end
   end

   // Strobes are pure decodes of state; reset therefore kills any outstanding req at once.
   always_comb begin
      w_next       = S_IDLE;
      w_imem_req   = 1'b0;
      w_ir_we      = 1'b0;
      w_pc_we      = 1'b0;
      w_pc_we_cond = 1'b0;
      w_pc_src     = 2'b00;
      w_dmem_req   = 1'b0;
      w_dmem_we    = 1'b0;
      w_mdr_we     = 1'b0;
      w_rf_we      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: w_next = S_IF;
         S_IF: begin
            w_imem_req = 1'b1;
            w_next     = S_IF;
            if (bus.imem_ready) begin
               w_ir_we = 1'b1;
               w_pc_we = 1'b1;
               w_next  = S_ID;
            end
         end
         S_ID: w_next = S_EX;
         S_EX: begin
            w_next = S_IF;
            if (r_branch) begin
               w_pc_we_cond = 1'b1;
               w_pc_src     = 2'b01;
               w_done       = 1'b1;
            end else if (r_jumptoreg) begin
               w_pc_we  = 1'b1;
               w_pc_src = 2'b11;
               w_done   = 1'b1;
            end else if (r_jump) begin
               w_pc_we  = 1'b1;
               w_pc_src = 2'b10;
               if (r_regwrite && r_regdst_ra) w_next = S_WB;
               else                           w_done = 1'b1;
            end else if (r_memread || r_memwrite) begin
               w_next = S_MEM;
            end else if (r_regwrite) begin
               w_next = S_WB;
            end else begin
               w_done = 1'b1;
            end
         end
         S_MEM: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = r_memwrite;
            w_next     = S_MEM;
            if (bus.dmem_ready) begin
               // Read wins when both are set: the access still writes but completes as a load.
               if (r_memread) begin
                  w_mdr_we = 1'b1;
                  w_next   = S_WB;
               end else begin
                  w_done = 1'b1;
                  w_next = S_IF;
               end
            end
         end
         S_WB: begin
            w_rf_we = 1'b1;
            w_done  = 1'b1;
            w_next  = S_IF;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.imem_req   = w_imem_req;
   assign bus.ir_we      = w_ir_we;
   assign bus.pc_we      = w_pc_we;
   assign bus.pc_we_cond = w_pc_we_cond;
   assign bus.pc_src     = w_pc_src;
   assign bus.dmem_req   = w_dmem_req;
   assign bus.dmem_we    = w_dmem_we;
   assign bus.mdr_we     = w_mdr_we;
   assign bus.rf_we      = w_rf_we;
   assign bus.instr_done = w_done;
   assign bus.state      = r_state;
   assign bus.alu_ctrl_q = r_aluctrl;
   assign bus.ctrl_q     = {r_regdst, r_alusrc, r_memtoreg, r_regdst_ra};

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] r_cycle_cnt, r_instr_cnt, r_stall_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (r_state != S_IDLE) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (w_done)            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
         if ((w_imem_req && !bus.imem_ready) || (w_dmem_req && !bus.dmem_ready))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end
   assign bus.cycle_cnt = r_cycle_cnt;
   assign bus.instr_cnt = r_instr_cnt;
   assign bus.stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-instruction cycle schedules built from the step rules,
// checked every cycle, with random control noise outside ID and random ready outside req.
module tb_mc_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mc_sequencer_if bus ();
   mc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump, RegDst_ra, JumptoReg;
   } ctl_t;
   typedef enum {K_R, K_LW, K_SW, K_BEQ, K_J, K_JR, K_JAL, K_NOP, K_LWSW, K_BRP} kind_t;
   typedef struct {
      int       st;
      bit       irdy, drdy;
      ctl_t     ctl;
      bit [3:0] alu;
      bit       imem_req, ir_we, pc_we, pc_we_cond;
      bit [1:0] pc_src;
      bit       dmem_req, dmem_we, mdr_we, rf_we, done;
      bit [3:0] xctrl, xalu;
   } rec_t;

   rec_t     q[$];
   int       n_chk = 0, n_fail = 0, cyc_no = 0;
   bit [3:0] lat_ctrl = 4'd0, lat_alu = 4'd0;
   longint   cyc_m = 0, ins_m = 0, stl_m = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc_no, act, exp);
      end
   endtask

   function automatic rec_t blank(input int st);
      rec_t r;
      r       = '{default: 0};
      r.st    = st;
      r.irdy  = 1'($urandom);
      r.drdy  = 1'($urandom);
      r.ctl   = ctl_t'(10'($urandom));
      r.alu   = 4'($urandom);
      r.xctrl = lat_ctrl;
      r.xalu  = lat_alu;
      return r;
   endfunction

   function automatic ctl_t ctl_of(input kind_t k);
      ctl_t c;
      c = '0;
      case (k)
         K_R:    begin c.RegDst = 1; c.RegWrite = 1; end
         K_LW:   begin c.ALUSrc = 1; c.MemToReg = 1; c.RegWrite = 1; c.MemRead = 1; end
         K_SW:   begin c.ALUSrc = 1; c.MemWrite = 1; end
         K_BEQ:  c.Branch = 1;
         K_J:    c.Jump = 1;
         K_JR:   c.JumptoReg = 1;
         K_JAL:  begin c.Jump = 1; c.RegWrite = 1; c.RegDst_ra = 1; end
         K_LWSW: begin c.ALUSrc = 1; c.MemToReg = 1; c.RegWrite = 1; c.MemRead = 1; c.MemWrite = 1; end
         K_BRP:  begin c.Branch = 1; c.Jump = 1; c.RegWrite = 1; c.MemRead = 1; c.RegDst = 1; end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Expected cycle-by-cycle behaviour of one instruction, by instruction class.
   task automatic build(input kind_t k, input int wi, input int wd, output int n);
      rec_t r;
      ctl_t c;
      bit   ld, wr;
      n = 0;
      for (int i = 0; i < wi; i++) begin
         r = blank(1); r.irdy = 0; r.imem_req = 1; q.push_back(r); n++;
      end
      r = blank(1); r.irdy = 1; r.imem_req = 1; r.ir_we = 1; r.pc_we = 1; q.push_back(r); n++;
      c = ctl_of(k);
      r = blank(2); r.ctl = c; r.alu = 4'(int'(k) * 3 + 1); q.push_back(r); n++;
      lat_ctrl = {c.RegDst, c.ALUSrc, c.MemToReg, c.RegDst_ra};
      lat_alu  = r.alu;
      r = blank(3);
      case (k)
         K_BEQ, K_BRP: begin r.pc_we_cond = 1; r.pc_src = 2'b01; r.done = 1; q.push_back(r); n++; return; end
         K_JR:         begin r.pc_we = 1; r.pc_src = 2'b11; r.done = 1; q.push_back(r); n++; return; end
         K_J:          begin r.pc_we = 1; r.pc_src = 2'b10; r.done = 1; q.push_back(r); n++; return; end
         K_NOP:        begin r.done = 1; q.push_back(r); n++; return; end
         K_JAL:        begin r.pc_we = 1; r.pc_src = 2'b10; q.push_back(r); n++; end
         K_R:          begin q.push_back(r); n++; end
         default: begin
            q.push_back(r); n++;
            ld = (k != K_SW);
            wr = (k != K_LW);
            for (int i = 0; i < wd; i++) begin
               r = blank(4); r.drdy = 0; r.dmem_req = 1; r.dmem_we = wr; q.push_back(r); n++;
            end
            r = blank(4); r.drdy = 1; r.dmem_req = 1; r.dmem_we = wr;
            r.mdr_we = ld; r.done = !ld; q.push_back(r); n++;
            if (!ld) return;
         end
      endcase
      r = blank(5); r.rf_we = 1; r.done = 1; q.push_back(r); n++;
   endtask

   // Called at posedge+1: drive this cycle, check it, advance to the next posedge+1.
   task automatic step();
      rec_t r;
      r = q.pop_front();
      cyc_no++;
      {bus.RegDst, bus.ALUSrc, bus.MemToReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
       bus.Branch, bus.Jump, bus.RegDst_ra, bus.JumptoReg} = r.ctl;
      bus.ALUctrl    = r.alu;
      bus.imem_ready = r.irdy;
      bus.dmem_ready = r.drdy;
      #3;
      chk("state",      64'(bus.state),      64'(r.st));
      chk("imem_req",   64'(bus.imem_req),   64'(r.imem_req));
      chk("ir_we",      64'(bus.ir_we),      64'(r.ir_we));
      chk("pc_we",      64'(bus.pc_we),      64'(r.pc_we));
      chk("pc_we_cond", 64'(bus.pc_we_cond), 64'(r.pc_we_cond));
      chk("pc_src",     64'(bus.pc_src),     64'(r.pc_src));
      chk("dmem_req",   64'(bus.dmem_req),   64'(r.dmem_req));
      chk("dmem_we",    64'(bus.dmem_we),    64'(r.dmem_we));
      chk("mdr_we",     64'(bus.mdr_we),     64'(r.mdr_we));
      chk("rf_we",      64'(bus.rf_we),      64'(r.rf_we));
      chk("instr_done", 64'(bus.instr_done), 64'(r.done));
      chk("ctrl_q",     64'(bus.ctrl_q),     64'(r.xctrl));
      chk("alu_ctrl_q", 64'(bus.alu_ctrl_q), 64'(r.xalu));
`ifdef MC_PERF_CNT_EN
      chk("cycle_cnt",  64'(bus.cycle_cnt),  64'(cyc_m));
      chk("instr_cnt",  64'(bus.instr_cnt),  64'(ins_m));
      chk("stall_cnt",  64'(bus.stall_cnt),  64'(stl_m));
`endif
      if (r.st != 0) cyc_m++;
      if (r.done) ins_m++;
      if ((r.imem_req && !r.irdy) || (r.dmem_req && !r.drdy)) stl_m++;
      @(posedge clk); #1;
   endtask

   task automatic run_all();
      while (q.size() > 0) step();
   endtask

   task automatic reset_model();
      lat_ctrl = 4'd0; lat_alu = 4'd0;
      cyc_m = 0; ins_m = 0; stl_m = 0;
      q.delete();
      q.push_back(blank(0));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_state"},    64'(bus.state),      64'd0);
      chk({tag, "_dmem_req"}, 64'(bus.dmem_req),   64'd0);
      chk({tag, "_imem_req"}, 64'(bus.imem_req),   64'd0);
      chk({tag, "_done"},     64'(bus.instr_done), 64'd0);
      chk({tag, "_ctrl_q"},   64'(bus.ctrl_q),     64'd0);
      chk({tag, "_alu_q"},    64'(bus.alu_ctrl_q), 64'd0);
`ifdef MC_PERF_CNT_EN
      chk({tag, "_cyc"},      64'(bus.cycle_cnt),  64'd0);
      chk({tag, "_ins"},      64'(bus.instr_cnt),  64'd0);
      chk({tag, "_stl"},      64'(bus.stall_cnt),  64'd0);
`endif
   endtask

   initial begin
      int n;
      {bus.RegDst, bus.ALUSrc, bus.MemToReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
       bus.Branch, bus.Jump, bus.RegDst_ra, bus.JumptoReg} = '1;
      bus.ALUctrl = 4'hF; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst = 1'b0;
      reset_model();

      // R-type then lw with three data wait states; pin schedule lengths and counters.
      build(K_R, 0, 0, n);  chk("len_R", 64'(n), 64'd4);
      build(K_LW, 0, 3, n); chk("len_LW_wait3", 64'(n), 64'd8);
      run_all();
`ifdef MC_PERF_CNT_EN
      chk("lit_cycle_cnt", 64'(bus.cycle_cnt), 64'd12);
      chk("lit_instr_cnt", 64'(bus.instr_cnt), 64'd2);
      chk("lit_stall_cnt", 64'(bus.stall_cnt), 64'd3);
`endif

      build(K_SW, 0, 0, n);   chk("len_SW", 64'(n), 64'd4);
      build(K_BEQ, 0, 0, n);  chk("len_BEQ", 64'(n), 64'd3);
      build(K_J, 0, 0, n);    chk("len_J", 64'(n), 64'd3);
      build(K_JR, 0, 0, n);   chk("len_JR", 64'(n), 64'd3);
      build(K_JAL, 0, 0, n);  chk("len_JAL", 64'(n), 64'd4);
      build(K_LW, 0, 0, n);   chk("len_LW", 64'(n), 64'd5);
      build(K_NOP, 0, 0, n);  chk("len_NOP", 64'(n), 64'd3);
      build(K_LWSW, 1, 2, n); chk("len_LWSW", 64'(n), 64'd8);
      build(K_BRP, 0, 0, n);  chk("len_BRP", 64'(n), 64'd3);
      build(K_R, 2, 0, n);    chk("len_R_iwait2", 64'(n), 64'd6);
      build(K_SW, 1, 1, n);   chk("len_SW_wait", 64'(n), 64'd6);
      run_all();

      // Reset in the middle of a data-memory wait.
      build(K_LW, 0, 10, n);
      repeat (5) step();
      q.delete();
      bus.dmem_ready = 1'b0;
      #1;
      chk("pre_rst_dmem_req", 64'(bus.dmem_req), 64'd1);
      rst = 1'b1;
      #1;
      chk_reset_state("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      reset_model();
      build(K_R, 0, 0, n);
      build(K_JAL, 1, 0, n);
      run_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
